booth_encoder: RTL and testbench

Radix-8 (modified Booth, 3-bit recoding) partial-product generator for unsigned operands. It recodes `multiplier` into signed digits in {-4..+4} and forms one two's-complement partial product per digit from `multiplicand`. The partial products are emitted side by side on one registered bus. It feeds the downstream partial-product reduction tree and final adder of the multiplier datapath; it performs no summation itself.

---
 rtl/booth_encoder.sv | 107 ++++++++++
 tb/tb_booth_encoder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/booth_encoder.sv
`default_nettype none
// ============================================================================
// Module      : booth_encoder
// Description : Radix-8 Booth partial-product generator for unsigned operands.
//               The multiplier is recoded into NUM_TERMS signed digits in
//               {-4..+4}. Each digit selects a multiple of the multiplicand,
//               which is negated in the same cycle when the digit is negative.
//               All partial products are registered side by side on one bus.
//               No summation is done here; a reduction tree consumes result.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in  1                 rising-edge clock
//   rst          in  1                 synchronous active-high reset
//   multiplicand in  DATA_WIDTH        unsigned operand A
//   multiplier   in  DATA_WIDTH        unsigned operand B (Booth-recoded)
//   result       out CAPACITY_RESULT   {pp[NUM_TERMS-1], ..., pp[1], pp[0]},
//                                      each pp PP_WIDTH bits, two's complement
// ============================================================================
module booth_encoder #(
    parameter int DATA_WIDTH = 6
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic [DATA_WIDTH-1:0]                                multiplicand,
    input  logic [DATA_WIDTH-1:0]                                multiplier,
    output logic [(2*DATA_WIDTH-1)*(DATA_WIDTH/3+1)-1:0]         result
);

    localparam int NUM_TERMS       = DATA_WIDTH / 3 + 1;
    localparam int PP_WIDTH        = 2 * DATA_WIDTH - 1;
    localparam int CAPACITY_RESULT = PP_WIDTH * NUM_TERMS;
    // Extended multiplier: 3*NUM_TERMS data bits plus the implicit b[-1] at bit 0.
    localparam int EXT_WIDTH       = 3 * NUM_TERMS + 1;
    localparam int PAD_B           = 3 * NUM_TERMS - DATA_WIDTH;
    localparam int PAD_A           = PP_WIDTH - DATA_WIDTH;

    localparam logic [PP_WIDTH-1:0] c_pp_one  = PP_WIDTH'(1);
    localparam logic [PP_WIDTH-1:0] c_pp_zero = '0;

    // Combinational partial products, one per Booth digit.
    logic [PP_WIDTH-1:0]        ir_result [NUM_TERMS];

    logic [EXT_WIDTH-1:0]       w_b_ext;
    logic [PP_WIDTH-1:0]        w_a1;
    logic [PP_WIDTH-1:0]        w_a2;
    logic [PP_WIDTH-1:0]        w_a3;
    logic [PP_WIDTH-1:0]        w_a4;
    logic [CAPACITY_RESULT-1:0] w_concat;

    // Bit k+1 of w_b_ext is b[k]; bit 0 is b[-1] = 0.
    assign w_b_ext = {{PAD_B{1'b0}}, multiplier, 1'b0};

    // Shared multiples. 3A is the only one needing an adder and is built once.
    assign w_a1 = {{PAD_A{1'b0}}, multiplicand};
    assign w_a2 = w_a1 << 1;
    assign w_a4 = w_a1 << 2;
    assign w_a3 = w_a1 + w_a2;

    generate
        for (genvar gi = 0; gi < NUM_TERMS; gi++) begin : g_terms
            logic [3:0]          w_win;
            logic [PP_WIDTH-1:0] w_mag;
            logic                w_neg;

            // Window {b[3i+2], b[3i+1], b[3i], b[3i-1]}.
            assign w_win = w_b_ext[3*gi+3 -: 4];

            always_comb begin
                w_mag = c_pp_zero;
                w_neg = 1'b0;
                case (w_win)
                    4'b0000: begin w_mag = c_pp_zero; w_neg = 1'b0; end
                    4'b0001: begin w_mag = w_a1;      w_neg = 1'b0; end
                    4'b0010: begin w_mag = w_a1;      w_neg = 1'b0; end
                    4'b0011: begin w_mag = w_a2;      w_neg = 1'b0; end
                    4'b0100: begin w_mag = w_a2;      w_neg = 1'b0; end
                    4'b0101: begin w_mag = w_a3;      w_neg = 1'b0; end
                    4'b0110: begin w_mag = w_a3;      w_neg = 1'b0; end
                    4'b0111: begin w_mag = w_a4;      w_neg = 1'b0; end
                    4'b1000: begin w_mag = w_a4;      w_neg = 1'b1; end
                    4'b1001: begin w_mag = w_a3;      w_neg = 1'b1; end
                    4'b1010: begin w_mag = w_a3;      w_neg = 1'b1; end
                    4'b1011: begin w_mag = w_a2;      w_neg = 1'b1; end
                    4'b1100: begin w_mag = w_a2;      w_neg = 1'b1; end
                    4'b1101: begin w_mag = w_a1;      w_neg = 1'b1; end
                    4'b1110: begin w_mag = w_a1;      w_neg = 1'b1; end
                    default: begin w_mag = c_pp_zero; w_neg = 1'b0; end
                endcase
            end

            // Full negation (invert + 1) in-cycle; a zero magnitude stays zero.
            assign ir_result[gi] = w_neg ? (~w_mag + c_pp_one) : w_mag;
            assign w_concat[PP_WIDTH*gi +: PP_WIDTH] = ir_result[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
        end else begin
            result <= w_concat;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_booth_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_encoder
// Description : Scoreboard bench for booth_encoder (DATA_WIDTH = 6). A driver
//               issues one operand pair per cycle and queues the expected
//               registered result; a monitor pops and compares after each
//               edge. Expected values come from constants for the directed
//               vectors and from an arithmetic digit model otherwise; the
//               sum-of-partial-products identity is also checked.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_encoder;

    localparam int N   = 6;
    localparam int NT  = N / 3 + 1;
    localparam int PW  = 2 * N - 1;
    localparam int CAP = PW * NT;

    typedef struct {
        logic [CAP-1:0] exp;
        int             a;
        int             b;
        bit             chk_sum;
    } item_t;

    logic           clk;
    logic           rst;
    logic [N-1:0]   multiplicand;
    logic [N-1:0]   multiplier;
    logic [CAP-1:0] result;

    item_t q[$];
    int    tests;
    int    fails;

    booth_encoder #(.DATA_WIDTH(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .result       (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int bit_of(input int v, input int k);
        if (k < 0) return 0;
        return (v >> k) & 1;
    endfunction

    // Digit d_i = -4*b[3i+2] + 2*b[3i+1] + b[3i] + b[3i-1]; pp_i = d_i*A.
    function automatic logic [CAP-1:0] model(input int a, input int b);
        logic [CAP-1:0] r;
        logic [31:0]    p;
        int             d;
        r = '0;
        for (int i = 0; i < NT; i++) begin
            d = -4 * bit_of(b, 3*i+2) + 2 * bit_of(b, 3*i+1)
                + bit_of(b, 3*i) + bit_of(b, 3*i-1);
            p = 32'(d * a);
            r[PW*i +: PW] = p[PW-1:0];
        end
        return r;
    endfunction

    function automatic longint pp_sum(input logic [CAP-1:0] r);
        longint s;
        longint v;
        s = 0;
        for (int i = 0; i < NT; i++) begin
            v = longint'(r[PW*i +: PW]);
            if (v >= (64'sd1 <<< (PW-1))) v = v - (64'sd1 <<< PW);
            s = s + v * (64'sd1 <<< (3*i));
        end
        return s;
    endfunction

    task automatic issue(input int a, input int b, input bit r,
                         input bit has_exp, input logic [CAP-1:0] cexp);
        item_t          it;
        logic [CAP-1:0] m;
        @(negedge clk);
        multiplicand = N'(a);
        multiplier   = N'(b);
        rst          = r;
        m = model(a, b);
        it.exp     = r ? '0 : (has_exp ? cexp : m);
        it.a       = a;
        it.b       = b;
        it.chk_sum = !r;
        q.push_back(it);
        #1;
        for (int i = 0; i < NT; i++) begin
            tests++;
            if (dut.ir_result[i] !== m[PW*i +: PW]) begin
                fails++;
                $display("FAIL ir_result[%0d] A=%0d B=%0d: got %h expected %h",
                         i, a, b, dut.ir_result[i], m[PW*i +: PW]);
            end
        end
    endtask

    // Monitor: one registered result per edge, matched in issue order.
    always @(posedge clk) begin
        item_t it;
        #1;
        if (q.size() > 0) begin
            it = q.pop_front();
            tests++;
            if (result !== it.exp) begin
                fails++;
                $display("FAIL result A=%0d B=%0d: got %h expected %h",
                         it.a, it.b, result, it.exp);
            end
            if (it.chk_sum) begin
                tests++;
                if (pp_sum(result) != longint'(it.a * it.b)) begin
                    fails++;
                    $display("FAIL pp_sum A=%0d B=%0d: got %0d expected %0d",
                             it.a, it.b, pp_sum(result), it.a * it.b);
                end
            end
        end
    end

    initial begin
        int wait_cycles;
        tests        = 0;
        fails        = 0;
        rst          = 1'b1;
        multiplicand = 6'b110101;
        multiplier   = 6'b011011;

        // Reset held for two edges with live operands: output must stay zero.
        issue(53, 27, 1'b1, 1'b0, '0);
        issue(53, 27, 1'b1, 1'b0, '0);

        // Directed vectors with hand-derived expected buses.
        issue(53, 27, 1'b0, 1'b1, {11'd0,  11'd159,  11'd159});
        issue(63, 63, 1'b0, 1'b1, {11'd63, 11'd0,    11'h7C1});
        issue(63, 28, 1'b0, 1'b1, {11'd0,  11'd252,  11'h704});
        issue(1,  36, 1'b0, 1'b1, {11'd1,  11'h7FD,  11'h7FC});
        for (int k = 0; k < 8; k++) begin
            issue(0, int'($urandom_range(0, 63)), 1'b0, 1'b1, '0);
        end

        // Random pairs against the arithmetic model.
        for (int k = 0; k < 200; k++) begin
            issue(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                  1'b0, 1'b0, '0);
        end

        // Exhaustive sweep with a mid-stream reset cycle.
        for (int a = 0; a < 64; a++) begin
            for (int b = 0; b < 64; b++) begin
                if (a == 31 && b == 17) begin
                    issue(a, b, 1'b1, 1'b0, '0);
                end
                issue(a, b, 1'b0, 1'b0, '0);
            end
        end

        @(negedge clk);
        rst = 1'b0;
        wait_cycles = 0;
        while (q.size() > 0 && wait_cycles < 10) begin
            @(negedge clk);
            wait_cycles++;
        end
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
